mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
// Memory-stage sequencer; consumes the EX/MEM pipeline register outputs (address, store data, MEMREAD/MEMWRITE, HALT).
// Drives a multi-cycle data memory through a request/done handshake.
// Produces the stall that freezes IF..EX/MEM until the access completes, and load data/valid for MEM/WB.
// Flags misaligned, conflicting or timed-out accesses.
// PARAMETERS
// DATA_W   16  data/address width (one 16-bit word per access)
// TIMEOUT  16  max WAIT cycles before abort; legal range 2..255
// PORTS
// clk          in   1       system clock, all state updates on rising edge
// rst          in   1       synchronous reset, ACTIVE-LOW (rst==0 resets on next clk edge)
// addr_mem     in   DATA_W  ALU_out_mem, byte address
// wdata_mem    in   DATA_W  ALU_operand2before_mem, store data
// memread_mem  in   1       load in MEM stage
// memwrite_mem in   1       store in MEM stage
// halt_mem     in   1       HALT in MEM stage
// mem_en       out  1       request strobe to data memory, 1-cycle pulse
// mem_wr       out  1       1=write, 0=read; valid with mem_en
// mem_addr     out  DATA_W  request address; valid with mem_en
// mem_wdata    out  DATA_W  request write data; valid with mem_en
// mem_done     in   1       memory completion, 1-cycle pulse; mem_rdata valid same cycle
// mem_rdata    in   DATA_W  read data
// stall_out    out  1       hold all upstream pipeline registers
// rdata_out    out  DATA_W  registered load data to MEM/WB
// rdata_valid  out  1       rdata_out valid this cycle
// err_out      out  1       access error, 1-cycle pulse
// halt_out     out  1       HALT committed from MEM stage
// BEHAVIOUR
// - Reset (rst==0 at edge): state=IDLE, counter=0.
// - Reset values: mem_en=0, stall_out=0, rdata_valid=0, err_out=0, halt_out=0, rdata_out=0.
// - Reset mid-access abandons the outstanding request; any later mem_done in IDLE is ignored.
// - Define op = memread_mem|memwrite_mem.
// - IDLE, op=0: no request, no stall; halt_out=halt_mem (combinational).
// - IDLE, error case: op=1 with addr_mem[0]=1, or memread_mem & memwrite_mem both 1.
//   -> no request; err_out=1 this cycle; stall_out=0; stay IDLE.
// - IDLE, legal op: mem_en=1 this cycle (combinational from inputs).
//   mem_wr=memwrite_mem, mem_addr=addr_mem, mem_wdata=wdata_mem; stall_out=1; next WAIT; counter=0.
// - WAIT: mem_en=0, stall_out=1, counter++.
//   mem_done=1 -> capture mem_rdata into rdata_out for reads (rdata_out unchanged on writes); next DONE.
//   Else counter==TIMEOUT-1 -> next ABORT.
// - DONE: stall_out=0; rdata_valid=1 for reads only; inputs ignored (same instruction still held); next IDLE.
// - ABORT: stall_out=0, err_out=1, rdata_valid=0; next IDLE.
// - mem_done is sampled only in WAIT; done in IDLE/DONE/ABORT is dropped.
// - mem_done on the same cycle the counter reaches TIMEOUT-1: done wins.
// - Latency: a load issued at cycle T with done at T+k (k>=1) gives rdata_valid at T+k+1.
//   Stall is high T..T+k, so the pipeline freezes k+1 cycles.
// - halt_out is asserted only from IDLE; HALT co-resident with a legal op commits in the IDLE after DONE/ABORT.
// - Counter width $clog2(TIMEOUT); no wrap, it is cleared on entering WAIT.
// STRUCTURE
// - Package mem_stage_pkg: state enum {IDLE,WAIT,DONE,ABORT}; ALIGN_MASK=16'h0001; default TIMEOUT.
// - Sub-module mem_timeout_cnt: clear/enable counter with expired flag, parameterised by TIMEOUT.
// - Remainder is a single FSM plus output mux.
// TESTING
// 1. Load addr=16'h0010, done 3 cycles after mem_en, rdata=16'hBEEF.
//    -> stall 4 cycles; rdata_valid for 1 cycle with rdata_out=BEEF; no second mem_en.
// 2. Store addr=16'h0020, wdata=16'h1234, done after 1 cycle.
//    -> mem_en=1, mem_wr=1, mem_wdata=1234; stall 2 cycles; rdata_valid stays 0.
// 3. Load addr=16'h0013 -> err_out pulse for 1 cycle; mem_en=0; stall_out=0.
//    memread_mem & memwrite_mem both 1 -> err_out pulse; mem_en=0.
// 4. Load with no mem_done, TIMEOUT=16 -> stall high 16 cycles, then err_out 1 cycle; then back to IDLE.
//    A mem_done arriving afterwards is ignored.
// 5. rst=0 two cycles into WAIT -> next cycle all outputs at reset values.
//    The following legal load issues a fresh mem_en.
// 6. HALT co-resident with a load -> halt_out low during stall, high in the IDLE cycle after DONE.
//    Back-to-back loads -> exactly one mem_en each, separated by DONE.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the memory-stage sequencer.
package mem_stage_pkg;

    // Sequencer states: idle/issue, waiting for completion, result cycle, timeout.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_t;

    // Bits of a byte address that must be zero for a 16-bit word access.
    localparam logic [15:0] ALIGN_MASK = 16'h0001;

    // Default maximum number of cycles spent waiting on the memory.
    localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Wait-cycle counter: cleared when a request is issued, counts while the
// sequencer waits, and flags the cycle on which it reaches TIMEOUT-1.
module mem_timeout_cnt #(
    parameter int TIMEOUT = 16,
    parameter int CW      = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // Value held during the last permitted wait cycle; the increment taken
    // on that cycle brings the count to TIMEOUT-1.
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 2);
    localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    // Next count: clear has priority, otherwise saturating increment.
    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en && (count_reg != CNT_MAX)) begin
            count_next = count_reg + CW'(1);
        end
    end

    // Counter register, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expired = en && (count_reg == LAST_WAIT);

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer: issues one request per load/store, stalls the
// upstream pipeline until the memory answers or times out, returns load data
// to MEM/WB and reports misaligned, conflicting or timed-out accesses.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] addr_mem,
    input  logic [DATA_W-1:0] wdata_mem,
    input  logic              memread_mem,
    input  logic              memwrite_mem,
    input  logic              halt_mem,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_out,
    output logic [DATA_W-1:0] rdata_out,
    output logic              rdata_valid,
    output logic              err_out,
    output logic              halt_out
);

    localparam logic [DATA_W-1:0] ADDR_MASK = DATA_W'(ALIGN_MASK);

    state_t            state_reg, state_next;
    logic              wr_reg, wr_next;
    logic              halt_pend_reg, halt_pend_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;

    logic              cnt_clr;
    logic              cnt_en;
    logic              cnt_expired;

    logic [DATA_W-1:0] addr_masked;
    logic              op;
    logic              bad_op;
    logic              legal_op;

    // Per-bit alignment mask of the incoming byte address.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_align
            assign addr_masked[gi] = addr_mem[gi] & ADDR_MASK[gi];
        end
    endgenerate

    assign op       = memread_mem | memwrite_mem;
    assign bad_op   = op & ((|addr_masked) | (memread_mem & memwrite_mem));
    assign legal_op = op & ~bad_op;

    // Request fields pass straight through; they are qualified by mem_en.
    assign mem_wr    = memwrite_mem;
    assign mem_addr  = addr_mem;
    assign mem_wdata = wdata_mem;
    assign rdata_out = rdata_reg;

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (cnt_expired)
    );

    // Next-state logic and output mux; everything is held quiet while in reset.
    always_comb begin
        state_next     = state_reg;
        wr_next        = wr_reg;
        halt_pend_next = halt_pend_reg;
        rdata_next     = rdata_reg;
        cnt_clr        = 1'b0;
        cnt_en         = 1'b0;
        mem_en         = 1'b0;
        stall_out      = 1'b0;
        rdata_valid    = 1'b0;
        err_out        = 1'b0;
        halt_out       = 1'b0;
        if (rst) begin
            case (state_reg)
                IDLE: begin
                    // A HALT that rode along with the previous access commits now.
                    halt_out       = halt_pend_reg | (halt_mem & ~op);
                    halt_pend_next = 1'b0;
                    if (bad_op) begin
                        err_out = 1'b1;
                    end else if (legal_op) begin
                        mem_en         = 1'b1;
                        stall_out      = 1'b1;
                        cnt_clr        = 1'b1;
                        wr_next        = memwrite_mem;
                        halt_pend_next = halt_mem;
                        state_next     = WAIT;
                    end
                end
                WAIT: begin
                    stall_out = 1'b1;
                    cnt_en    = 1'b1;
                    if (mem_done) begin
                        if (!wr_reg) begin
                            rdata_next = mem_rdata;
                        end
                        state_next = DONE;
                    end else if (cnt_expired) begin
                        state_next = ABORT;
                    end
                end
                DONE: begin
                    rdata_valid = ~wr_reg;
                    state_next  = IDLE;
                end
                ABORT: begin
                    err_out    = 1'b1;
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State and data registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            wr_reg        <= 1'b0;
            halt_pend_reg <= 1'b0;
            rdata_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            wr_reg        <= wr_next;
            halt_pend_reg <= halt_pend_next;
            rdata_reg     <= rdata_next;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_mem_stage_ctrl;

    localparam int DW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] addr_mem, wdata_mem, mem_rdata;
    logic          memread_mem, memwrite_mem, halt_mem, mem_done;
    logic          mem_en, mem_wr, stall_out, rdata_valid, err_out, halt_out;
    logic [DW-1:0] mem_addr, mem_wdata, rdata_out;

    int checks   = 0;
    int failures = 0;

    // Model state: one outstanding access described by its issue cycle and
    // the cycle on which its result (done or abort) becomes visible.
    bit            m_busy;
    bit            m_read;
    bit            m_end_done;
    bit            m_pend;
    int            m_cyc;
    int            m_issue;
    int            m_end;
    logic [DW-1:0] m_addr;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] m_rd_next;
    logic          e_en, e_stall, e_err, e_halt, e_valid, m_op, m_bad;

    // Random-phase driver variables.
    bit            quiet;
    int            kind;
    logic [DW-1:0] ra;

    always #5 clk = ~clk;

    mem_stage_ctrl #(
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .addr_mem     (addr_mem),
        .wdata_mem    (wdata_mem),
        .memread_mem  (memread_mem),
        .memwrite_mem (memwrite_mem),
        .halt_mem     (halt_mem),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_done     (mem_done),
        .mem_rdata    (mem_rdata),
        .stall_out    (stall_out),
        .rdata_out    (rdata_out),
        .rdata_valid  (rdata_valid),
        .err_out      (err_out),
        .halt_out     (halt_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs just after the rising edge, return at the falling edge.
    task automatic drive(input logic r, input logic rd, input logic wr, input logic h,
                         input logic [DW-1:0] a, input logic [DW-1:0] wd,
                         input logic d, input logic [DW-1:0] rv);
        @(posedge clk);
        #1;
        rst          = r;
        memread_mem  = rd;
        memwrite_mem = wr;
        halt_mem     = h;
        addr_mem     = a;
        wdata_mem    = wd;
        mem_done     = d;
        mem_rdata    = rv;
        @(negedge clk);
    endtask

    task automatic idle(input logic d);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, d, 16'hDEAD);
    endtask

    // Reference model and per-cycle comparison.
    initial begin
        m_busy  = 1'b0;
        m_pend  = 1'b0;
        m_cyc   = 0;
        m_rdata = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            m_cyc++;
            e_en = 0; e_stall = 0; e_err = 0; e_halt = 0; e_valid = 0;
            m_rd_next = m_rdata;
            if (!rst) begin
                m_busy    = 1'b0;
                m_pend    = 1'b0;
                m_rd_next = '0;
            end else if (!m_busy) begin
                m_op   = memread_mem | memwrite_mem;
                m_bad  = m_op && (addr_mem[0] || (memread_mem && memwrite_mem));
                e_halt = m_pend || (halt_mem && !m_op);
                m_pend = 1'b0;
                if (m_bad) begin
                    e_err = 1'b1;
                    $display("txn cyc=%0d rejected addr=%h rd=%0b wr=%0b",
                             m_cyc, addr_mem, memread_mem, memwrite_mem);
                end else if (m_op) begin
                    e_en       = 1'b1;
                    e_stall    = 1'b1;
                    m_busy     = 1'b1;
                    m_issue    = m_cyc;
                    m_end      = m_cyc + TO;
                    m_end_done = 1'b0;
                    m_read     = memread_mem;
                    m_addr     = addr_mem;
                    m_pend     = halt_mem;
                end
            end else if (m_cyc < m_end) begin
                e_stall = 1'b1;
                if (mem_done) begin
                    m_end      = m_cyc + 1;
                    m_end_done = 1'b1;
                    if (m_read) m_rd_next = mem_rdata;
                end
            end else begin
                if (m_end_done) e_valid = m_read;
                else            e_err   = 1'b1;
                m_busy = 1'b0;
                $display("txn cyc=%0d %s addr=%h latency=%0d %s", m_issue,
                         m_read ? "load " : "store", m_addr, m_cyc - m_issue,
                         m_end_done ? "done" : "timeout");
            end
            check("mem_en", mem_en, e_en);
            check("stall_out", stall_out, e_stall);
            check("err_out", err_out, e_err);
            check("halt_out", halt_out, e_halt);
            check("rdata_valid", rdata_valid, e_valid);
            check("rdata_out", rdata_out, m_rdata);
            if (e_en) begin
                check("mem_wr", mem_wr, memwrite_mem);
                check("mem_addr", mem_addr, addr_mem);
                check("mem_wdata", mem_wdata, wdata_mem);
            end
            m_rdata = m_rd_next;
        end
    end

    // Stimulus: reset, directed scenarios with literal expectations, random traffic.
    initial begin
        rst = 1'b0; memread_mem = 0; memwrite_mem = 0; halt_mem = 0;
        addr_mem = '0; wdata_mem = '0; mem_done = 0; mem_rdata = '0;
        drive(1'b0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        drive(1'b0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        idle(1'b0);
        check("reset_mem_en", mem_en, 1'b0);
        check("reset_stall", stall_out, 1'b0);
        check("reset_rdata_out", rdata_out, 16'h0000);

        // Load with completion three cycles after the request.
        drive(1, 1, 0, 0, 16'h0010, 16'h0, 0, 16'h0);
        check("t1_issue_en", mem_en, 1'b1);
        check("t1_issue_wr", mem_wr, 1'b0);
        check("t1_issue_addr", mem_addr, 16'h0010);
        check("t1_issue_stall", stall_out, 1'b1);
        drive(1, 1, 0, 0, 16'h0010, 16'h0, 0, 16'h0);
        check("t1_wait1_stall", stall_out, 1'b1);
        check("t1_wait1_en", mem_en, 1'b0);
        drive(1, 1, 0, 0, 16'h0010, 16'h0, 0, 16'h0);
        check("t1_wait2_stall", stall_out, 1'b1);
        drive(1, 1, 0, 0, 16'h0010, 16'h0, 1, 16'hBEEF);
        check("t1_done_stall", stall_out, 1'b1);
        drive(1, 1, 0, 0, 16'h0010, 16'h0, 0, 16'h0);
        check("t1_valid", rdata_valid, 1'b1);
        check("t1_rdata", rdata_out, 16'hBEEF);
        check("t1_no_reissue", mem_en, 1'b0);
        check("t1_stall_low", stall_out, 1'b0);
        idle(1'b0);
        check("t1_valid_pulse", rdata_valid, 1'b0);

        // Store completing after one cycle.
        drive(1, 0, 1, 0, 16'h0020, 16'h1234, 0, 16'h0);
        check("t2_en", mem_en, 1'b1);
        check("t2_wr", mem_wr, 1'b1);
        check("t2_wdata", mem_wdata, 16'h1234);
        drive(1, 0, 1, 0, 16'h0020, 16'h1234, 1, 16'hAAAA);
        check("t2_wait_stall", stall_out, 1'b1);
        drive(1, 0, 1, 0, 16'h0020, 16'h1234, 0, 16'h0);
        check("t2_no_valid", rdata_valid, 1'b0);
        check("t2_stall_low", stall_out, 1'b0);
        check("t2_rdata_kept", rdata_out, 16'hBEEF);
        idle(1'b0);

        // Misaligned load, then conflicting read+write.
        drive(1, 1, 0, 0, 16'h0013, 16'h0, 0, 16'h0);
        check("t3_mis_err", err_out, 1'b1);
        check("t3_mis_en", mem_en, 1'b0);
        check("t3_mis_stall", stall_out, 1'b0);
        drive(1, 1, 1, 0, 16'h0014, 16'h0, 0, 16'h0);
        check("t3_conf_err", err_out, 1'b1);
        check("t3_conf_en", mem_en, 1'b0);
        idle(1'b0);
        check("t3_err_pulse", err_out, 1'b0);

        // Load that never completes: 16 stall cycles, then a timeout error.
        drive(1, 1, 0, 0, 16'h0030, 16'h0, 0, 16'h0);
        check("t4_issue_stall", stall_out, 1'b1);
        for (int i = 1; i < TO; i++) begin
            drive(1, 1, 0, 0, 16'h0030, 16'h0, 0, 16'h0);
            check("t4_wait_stall", stall_out, 1'b1);
        end
        drive(1, 1, 0, 0, 16'h0030, 16'h0, 0, 16'h0);
        check("t4_abort_err", err_out, 1'b1);
        check("t4_abort_stall", stall_out, 1'b0);
        idle(1'b1);
        check("t4_late_done_err", err_out, 1'b0);
        check("t4_late_done_valid", rdata_valid, 1'b0);
        check("t4_late_done_stall", stall_out, 1'b0);

        // Reset two cycles into a wait, then a fresh load.
        drive(1, 1, 0, 0, 16'h0040, 16'h0, 0, 16'h0);
        drive(1, 1, 0, 0, 16'h0040, 16'h0, 0, 16'h0);
        drive(1, 1, 0, 0, 16'h0040, 16'h0, 0, 16'h0);
        drive(0, 1, 0, 0, 16'h0040, 16'h0, 0, 16'h0);
        idle(1'b1);
        check("t5_stall", stall_out, 1'b0);
        check("t5_valid", rdata_valid, 1'b0);
        check("t5_err", err_out, 1'b0);
        check("t5_rdata", rdata_out, 16'h0000);
        drive(1, 1, 0, 0, 16'h0042, 16'h0, 0, 16'h0);
        check("t5_fresh_en", mem_en, 1'b1);
        check("t5_fresh_addr", mem_addr, 16'h0042);
        drive(1, 1, 0, 0, 16'h0042, 16'h0, 1, 16'h5A5A);
        drive(1, 1, 0, 0, 16'h0042, 16'h0, 0, 16'h0);
        check("t5_fresh_rdata", rdata_out, 16'h5A5A);
        idle(1'b0);

        // HALT riding on a load, then back-to-back loads.
        drive(1, 1, 0, 1, 16'h0050, 16'h0, 0, 16'h0);
        check("t6_halt_issue", halt_out, 1'b0);
        drive(1, 1, 0, 1, 16'h0050, 16'h0, 1, 16'h1111);
        check("t6_halt_wait", halt_out, 1'b0);
        drive(1, 1, 0, 1, 16'h0050, 16'h0, 0, 16'h0);
        check("t6_halt_done", halt_out, 1'b0);
        drive(1, 0, 0, 1, 16'h0000, 16'h0, 0, 16'h0);
        check("t6_halt_commit", halt_out, 1'b1);
        idle(1'b0);
        check("t6_halt_clear", halt_out, 1'b0);
        drive(1, 1, 0, 0, 16'h0060, 16'h0, 0, 16'h0);
        check("t6_b2b_en1", mem_en, 1'b1);
        drive(1, 1, 0, 0, 16'h0060, 16'h0, 1, 16'h2222);
        check("t6_b2b_wait_en", mem_en, 1'b0);
        drive(1, 1, 0, 0, 16'h0060, 16'h0, 0, 16'h0);
        check("t6_b2b_done_en", mem_en, 1'b0);
        drive(1, 1, 0, 0, 16'h0062, 16'h0, 0, 16'h0);
        check("t6_b2b_en2", mem_en, 1'b1);
        drive(1, 1, 0, 0, 16'h0062, 16'h0, 1, 16'h3333);
        drive(1, 1, 0, 0, 16'h0062, 16'h0, 0, 16'h0);
        check("t6_b2b_rdata", rdata_out, 16'h3333);
        idle(1'b0);

        // Randomized traffic; quiet stretches withhold completions to force timeouts.
        quiet = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 200) == 0) quiet = ($urandom_range(0, 2) == 0);
            kind = $urandom_range(0, 9);
            ra   = DW'($urandom);
            if ($urandom_range(0, 7) != 0) ra[0] = 1'b0;
            drive(($urandom_range(0, 99) != 0),
                  (kind == 5 || kind == 6 || kind == 9),
                  (kind == 7 || kind == 8 || kind == 9),
                  ($urandom_range(0, 7) == 0),
                  ra, DW'($urandom),
                  quiet ? 1'b0 : ($urandom_range(0, 3) == 0),
                  DW'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
